// File: rtl/binary_to_ascii_stream_if.sv
// Valid/ready bundle between a binary producer, the ASCII converter and a
// character consumer (e.g. a UART transmitter).
interface binary_to_ascii_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] bin_in;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       char_out;
  logic             char_valid;
  logic             char_ready;
  logic             char_last;
  logic             busy;

  modport master (
    output bin_in, in_valid, char_ready,
    input  in_ready, char_out, char_valid, char_last, busy
  );

  modport slave (
    input  bin_in, in_valid, char_ready,
    output in_ready, char_out, char_valid, char_last, busy
  );
endinterface

// File: rtl/binary_to_ascii_stream.sv
// Iterative double-dabble binary-to-decimal converter emitting ASCII digits MSD first.
// Optional B2A_LZ_SUPPRESS_EN: skip leading zero digits (nibble 0 always emitted).
module binary_to_ascii_stream #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic                   clock,
  input logic                   reset,
  binary_to_ascii_stream_if.slave bus
);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  logic [1:0]       state_q, state_n;
  logic [WIDTH-1:0] bin_q, bin_n;
  logic [BCD_W-1:0] bcd_q, bcd_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             in_ready_q, in_ready_n;
  logic             busy_q, busy_n;
  logic [7:0]       char_out_q, char_out_n;
  logic             char_valid_q, char_valid_n;
  logic             char_last_q, char_last_n;

  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;
  logic [WIDTH-1:0] bin_shift;
  logic [IDX_W-1:0] idx_m1;
  logic [3:0]       nib_cur;
  logic [3:0]       nib_next;
  logic [3:0]       nib_top;

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.char_out   = char_out_q;
  assign bus.char_valid = char_valid_q;
  assign bus.char_last  = char_last_q;

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
    bin_shift = {bin_q[WIDTH-2:0], 1'b0};
  end

  assign idx_m1   = idx_q - IDX_W'(1);
  assign nib_cur  = bcd_q[{idx_q, 2'b00} +: 4];
  assign nib_next = bcd_q[{idx_m1, 2'b00} +: 4];
  assign nib_top  = bcd_shift[BCD_W-1 -: 4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      char_out_q   <= 8'h30;
      char_valid_q <= 1'b0;
      char_last_q  <= 1'b0;
    end else begin
      state_q      <= state_n;
      bin_q        <= bin_n;
      bcd_q        <= bcd_n;
      cnt_q        <= cnt_n;
      idx_q        <= idx_n;
      in_ready_q   <= in_ready_n;
      busy_q       <= busy_n;
      char_out_q   <= char_out_n;
      char_valid_q <= char_valid_n;
      char_last_q  <= char_last_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    bin_n        = bin_q;
    bcd_n        = bcd_q;
    cnt_n        = cnt_q;
    idx_n        = idx_q;
    in_ready_n   = in_ready_q;
    busy_n       = busy_q;
    char_out_n   = char_out_q;
    char_valid_n = char_valid_q;
    char_last_n  = char_last_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          bin_n      = bus.bin_in;
          bcd_n      = '0;
          cnt_n      = '0;
          in_ready_n = 1'b0;
          busy_n     = 1'b1;
          state_n    = S_CONVERT;
        end
      end

      S_CONVERT: begin
        bcd_n = bcd_shift;
        bin_n = bin_shift;
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_n = S_EMIT;
          idx_n   = IDX_W'(DIGITS - 1);
`ifndef B2A_LZ_SUPPRESS_EN
          // Present the most significant digit on the final shift edge.
          char_valid_n = 1'b1;
          char_out_n   = 8'h30 + {4'h0, nib_top};
          char_last_n  = (DIGITS == 1);
`endif
        end
      end

      S_EMIT: begin
`ifdef B2A_LZ_SUPPRESS_EN
        // Leading-zero scan runs with char_valid low, one nibble per cycle.
        if (!char_valid_q) begin
          if (nib_cur == 4'd0 && idx_q != '0) begin
            idx_n = idx_m1;
          end else begin
            char_valid_n = 1'b1;
            char_out_n   = 8'h30 + {4'h0, nib_cur};
            char_last_n  = (idx_q == '0);
          end
        end else
`endif
        if (char_valid_q && bus.char_ready) begin
          if (char_last_q) begin
            state_n      = S_IDLE;
            char_valid_n = 1'b0;
            char_last_n  = 1'b0;
            in_ready_n   = 1'b1;
            busy_n       = 1'b0;
            cnt_n        = '0;
            idx_n        = '0;
          end else begin
            idx_n       = idx_m1;
            char_out_n  = 8'h30 + {4'h0, nib_next};
            char_last_n = (idx_q == IDX_W'(1));
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_binary_to_ascii_stream.sv
// Scoreboard bench: stimulus pushes expected characters, per-instance monitors pop and compare.
module tb_binary_to_ascii_stream;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  binary_to_ascii_stream_if #(.WIDTH(8))  if_a ();
  binary_to_ascii_stream_if #(.WIDTH(16)) if_b ();

  binary_to_ascii_stream #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clock(clock), .reset(reset), .bus(if_a.slave));
  binary_to_ascii_stream #(.WIDTH(16), .DIGITS(5)) dut_b (
    .clock(clock), .reset(reset), .bus(if_b.slave));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [7:0] q_a_chr[$];
  bit         q_a_lst[$];
  logic [7:0] q_b_chr[$];
  bit         q_b_lst[$];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string lz(input string s);
`ifdef B2A_LZ_SUPPRESS_EN
    int i = 0;
    while (i < s.len() - 1 && s[i] == "0") i++;
    return s.substr(i, s.len() - 1);
`else
    return s;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_a(input string s);
    string e = lz(s);
    for (int i = 0; i < e.len(); i++) begin
      q_a_chr.push_back(e[i]);
      q_a_lst.push_back(i == e.len() - 1);
    end
  endtask

  task automatic push_b(input string s);
    string e = lz(s);
    for (int i = 0; i < e.len(); i++) begin
      q_b_chr.push_back(e[i]);
      q_b_lst.push_back(i == e.len() - 1);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; monitors sample on falling edges.
  task automatic send_a(input logic [7:0] v, input string exp, input bit push);
    int n = 0;
    @(posedge clock); #1;
    if_a.bin_in = v; if_a.in_valid = 1'b1;
    while (!if_a.in_ready && n < 200) begin @(posedge clock); #1; n++; end
    if (n >= 200) check("a_accept_timeout", 32'd1, 32'd0);
    if (push) push_a(exp);
    @(posedge clock); #1;
    acc_cyc = cyc;
    if_a.in_valid = 1'b0;
    if_a.bin_in = $urandom_range(0, 255);
  endtask

  task automatic send_b(input logic [15:0] v, input string exp);
    int n = 0;
    @(posedge clock); #1;
    if_b.bin_in = v; if_b.in_valid = 1'b1;
    while (!if_b.in_ready && n < 200) begin @(posedge clock); #1; n++; end
    if (n >= 200) check("b_accept_timeout", 32'd1, 32'd0);
    push_b(exp);
    @(posedge clock); #1;
    if_b.in_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (!(if_a.in_ready && q_a_chr.size() == 0) && n < 300) begin @(posedge clock); #1; n++; end
    check(name, 32'(q_a_chr.size()), 32'd0);
  endtask

  // Monitor A: scoreboard pop plus stall-stability check.
  bit         a_prev_stall = 1'b0;
  logic [7:0] a_prev_chr;
  logic       a_prev_lst;
  always @(negedge clock) begin
    if (!reset) begin
      if (a_prev_stall) begin
        check("a_stall_valid", 32'(if_a.char_valid), 32'd1);
        check("a_stall_char", 32'(if_a.char_out), 32'(a_prev_chr));
        check("a_stall_last", 32'(if_a.char_last), 32'(a_prev_lst));
      end
      if (if_a.char_valid && if_a.char_ready) begin
        if (q_a_chr.size() == 0) begin
          check("a_unexpected_char", 32'(if_a.char_out), 32'hFFFF);
        end else begin
          check("a_char", 32'(if_a.char_out), 32'(q_a_chr.pop_front()));
          check("a_last", 32'(if_a.char_last), 32'(q_a_lst.pop_front()));
        end
      end
      a_prev_stall = if_a.char_valid && !if_a.char_ready;
      a_prev_chr   = if_a.char_out;
      a_prev_lst   = if_a.char_last;
    end else begin
      a_prev_stall = 1'b0;
    end
  end

  // Monitor B: scoreboard pop.
  always @(negedge clock) begin
    if (!reset && if_b.char_valid && if_b.char_ready) begin
      if (q_b_chr.size() == 0) begin
        check("b_unexpected_char", 32'(if_b.char_out), 32'hFFFF);
      end else begin
        check("b_char", 32'(if_b.char_out), 32'(q_b_chr.pop_front()));
        check("b_last", 32'(if_b.char_last), 32'(q_b_lst.pop_front()));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(if_a.in_ready), 32'd1);
    check({tag, "_busy"}, 32'(if_a.busy), 32'd0);
    check({tag, "_char_valid"}, 32'(if_a.char_valid), 32'd0);
    check({tag, "_char_last"}, 32'(if_a.char_last), 32'd0);
    check({tag, "_char_out"}, 32'(if_a.char_out), 32'h30);
  endtask

  initial begin
    int n;
    if_a.bin_in = '0; if_a.in_valid = 1'b0; if_a.char_ready = 1'b1;
    if_b.bin_in = '0; if_b.in_valid = 1'b0; if_b.char_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("rst");
    check("rst_b_char_out", 32'(if_b.char_out), 32'h30);
    check("rst_b_in_ready", 32'(if_b.in_ready), 32'd1);
    reset = 1'b0;

    // Value 0 and value 9 (with latency check on 9).
    send_a(8'd0, "000", 1'b1);
    send_a(8'd9, "009", 1'b1);
    n = 0;
    while (!if_a.char_valid && n < 50) begin @(negedge clock); n++; end
`ifndef B2A_LZ_SUPPRESS_EN
    check("a_latency", 32'(cyc - acc_cyc), 32'd8);
`else
    check("a_valid_seen", 32'(if_a.char_valid), 32'd1);
`endif
    wait_idle_a("a_drain_9");

    // 255 with a five-cycle stall on every character.
    send_a(8'd255, "255", 1'b1);
    for (int c = 0; c < lz("255").len(); c++) begin
      #1 if_a.char_ready = 1'b0;
      n = 0;
      while (!if_a.char_valid && n < 50) begin @(posedge clock); #1; n++; end
      repeat (5) begin @(posedge clock); #1; end
      if_a.char_ready = 1'b1;
      @(posedge clock);
    end
    #1 if_a.char_ready = 1'b1;
    wait_idle_a("a_drain_255");

    // 123 with an ignored request (45) during conversion.
    send_a(8'd123, "123", 1'b1);
    check("a_busy_in_ready", 32'(if_a.in_ready), 32'd0);
    check("a_busy_flag", 32'(if_a.busy), 32'd1);
    if_a.bin_in = 8'd45; if_a.in_valid = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    if_a.in_valid = 1'b0;
    wait_idle_a("a_drain_123");
    check("a_ready_after_last", 32'(if_a.in_ready), 32'd1);

    // Reset three cycles into a conversion, then convert 5.
    send_a(8'd77, "077", 1'b0);
    repeat (2) begin @(posedge clock); end
    #1 reset = 1'b1;
    @(negedge clock);
    check_reset_vals("mid_rst");
    @(posedge clock); #1 reset = 1'b0;
    send_a(8'd5, "005", 1'b1);
    wait_idle_a("a_drain_5");

    // Wide instance, back to back.
    send_b(16'd65535, "65535");
    send_b(16'd1, "00001");
    n = 0;
    while (!(if_b.in_ready && q_b_chr.size() == 0) && n < 300) begin @(posedge clock); #1; n++; end
    check("b_drain", 32'(q_b_chr.size()), 32'd0);

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
